// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//
// Memory-mapped LED pattern player. A loadable table of NUM_STEPS colour
// words is replayed one word at a time onto the dmem store port (fixed
// address LED_ADDR, word store), with DWELL_CYCLES idle cycles between
// stores. Playback modes: one-shot, loop and (optionally) ping-pong.
//
// All state advances on the falling clock edge so the downstream memory,
// which samples on the rising edge, always sees settled address/data/wren.
//
// Optional feature macro: LED_SEQ_PINGPONG_EN
//   defined   - mode 2'b10 plays the table forwards then backwards without
//               repeating the endpoints.
//   undefined - no direction register is built; mode 2'b10 plays as loop.

module led_pattern_sequencer #(
  parameter int          NUM_STEPS    = 8,
  parameter int          DWELL_W      = 22,
  parameter int          DWELL_CYCLES = 3000000,
  parameter logic [31:0] LED_ADDR     = 32'hFFFFFFFC,
  localparam int         IDX_W        = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tbl_wren,
  input  logic [IDX_W-1:0] tbl_idx,
  input  logic [31:0]      tbl_data,
  input  logic [IDX_W:0]   seq_len,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             stop,
  output logic             dmem_wren,
  output logic [31:0]      dmem_address,
  output logic [31:0]      dmem_data_in,
  output logic [2:0]       funct3,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] step_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DWELL = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Dwell counter reload: counting DWELL_CYCLES-1 down to 0 gives exactly
  // DWELL_CYCLES idle cycles, so stores land DWELL_CYCLES+1 cycles apart.
  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W:0]     MAX_LEN    = (IDX_W + 1)'(NUM_STEPS);
  localparam logic [IDX_W:0]     LEN_ONE    = (IDX_W + 1)'(1);

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

  // Colour table
  logic [31:0] table_q [NUM_STEPS];

  // Sequencer state
  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [IDX_W:0]     len, len_nxt;
  logic [1:0]         mode_q, mode_nxt;
  logic [DWELL_W-1:0] count, count_nxt;
  logic [31:0]        data_q, data_nxt;
  logic [IDX_W-1:0]   step_q, step_nxt;

`ifdef LED_SEQ_PINGPONG_EN
  // Ping-pong direction: 0 = counting up, 1 = counting down.
  logic dir, dir_nxt;
`endif

  logic at_last;
  logic start_ok;
  logic tbl_hit;
  logic go_write;

  // Index sits on the last active step of the latched sequence.
  assign at_last  = ({1'b0, idx} == (len - LEN_ONE));

  // A start is only honoured with a usable length and no competing stop.
  assign start_ok = start && !stop && (seq_len != '0) && (seq_len <= MAX_LEN);

  // Table writes outside the physical depth are dropped.
  assign tbl_hit  = tbl_wren && ({1'b0, tbl_idx} < MAX_LEN);

  // Table storage: cleared by reset, writable at any time including playback.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        table_q[i] <= '0;
      end
    end else if (tbl_hit) begin
      table_q[tbl_idx] <= tbl_data;
    end
  end

  // Sequencer state register, including the latched output word and index.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      idx    <= '0;
      len    <= '0;
      mode_q <= '0;
      count  <= '0;
      data_q <= '0;
      step_q <= '0;
`ifdef LED_SEQ_PINGPONG_EN
      dir    <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      len    <= len_nxt;
      mode_q <= mode_nxt;
      count  <= count_nxt;
      data_q <= data_nxt;
      step_q <= step_nxt;
`ifdef LED_SEQ_PINGPONG_EN
      dir    <= dir_nxt;
`endif
    end
  end

  // Next-state logic: start/stop handling, dwell countdown and index stepping.
  // The output word is captured on entry to WRITE, so a table write to the
  // step on display only shows up the next time that step is stored.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    len_nxt   = len;
    mode_nxt  = mode_q;
    count_nxt = count;
    data_nxt  = data_q;
    step_nxt  = step_q;
    go_write  = 1'b0;
`ifdef LED_SEQ_PINGPONG_EN
    dir_nxt   = dir;
`endif

    case (state)
      IDLE: begin
        if (start_ok) begin
          len_nxt   = seq_len;
          mode_nxt  = mode;
          idx_nxt   = '0;
`ifdef LED_SEQ_PINGPONG_EN
          dir_nxt   = 1'b0;
`endif
          data_nxt  = table_q[0];
          step_nxt  = '0;
          state_nxt = WRITE;
        end
      end

      WRITE: begin
        if (stop) begin
          state_nxt = IDLE;
        end else begin
          count_nxt = DWELL_LOAD;
          state_nxt = DWELL;
        end
      end

      DWELL: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (count != '0) begin
          count_nxt = count - 1'b1;
        end else begin
          go_write = 1'b1;
          case (mode_q)
            MODE_ONESHOT: begin
              if (at_last) begin
                go_write  = 1'b0;
                state_nxt = DONE;
              end else begin
                idx_nxt = idx + 1'b1;
              end
            end
`ifdef LED_SEQ_PINGPONG_EN
            MODE_PINGPONG: begin
              if (!dir) begin
                if (at_last) begin
                  // A single-step sequence has nowhere to turn; it just repeats.
                  if (len == LEN_ONE) begin
                    idx_nxt = '0;
                  end else begin
                    dir_nxt = 1'b1;
                    idx_nxt = idx - 1'b1;
                  end
                end else begin
                  idx_nxt = idx + 1'b1;
                end
              end else begin
                if (idx == '0) begin
                  dir_nxt = 1'b0;
                  idx_nxt = idx + 1'b1;
                end else begin
                  idx_nxt = idx - 1'b1;
                end
              end
            end
`endif
            default: begin
              idx_nxt = at_last ? '0 : (idx + 1'b1);
            end
          endcase

          if (go_write) begin
            data_nxt  = table_q[idx_nxt];
            step_nxt  = idx_nxt;
            state_nxt = WRITE;
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Status and strobe outputs decode directly from the state register, so an
  // asynchronous reset drops them without waiting for a clock edge.
  assign dmem_wren    = (state == WRITE);
  assign busy         = (state == WRITE) || (state == DWELL);
  assign done         = (state == DONE);
  assign dmem_address = LED_ADDR;
  assign funct3       = 3'b010;
  assign dmem_data_in = data_q;
  assign step_idx     = step_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed testbench for led_pattern_sequencer (NUM_STEPS=6, DWELL_CYCLES=4).
// A monitor logs outputs each rising edge into arrays indexed from the first
// WRITE cycle of a playback; each test task checks the log against
// hand-derived expectations.

`timescale 1ns/1ps

module tb_led_pattern_sequencer;

  localparam int NSTEPS = 6;
  localparam int IW     = 3;
  localparam int LOG_N  = 256;

  logic          clk;
  logic          reset_n;
  logic          tbl_wren;
  logic [IW-1:0] tbl_idx;
  logic [31:0]   tbl_data;
  logic [IW:0]   seq_len;
  logic [1:0]    mode;
  logic          start;
  logic          stop;
  logic          dmem_wren;
  logic [31:0]   dmem_address;
  logic [31:0]   dmem_data_in;
  logic [2:0]    funct3;
  logic          busy;
  logic          done;
  logic [IW-1:0] step_idx;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_tbl [3];

  // Output log
  logic          log_en = 1'b0;
  int            cyc    = 0;
  logic          l_wren [LOG_N];
  logic [31:0]   l_data [LOG_N];
  logic [IW-1:0] l_step [LOG_N];
  logic          l_busy [LOG_N];
  logic          l_done [LOG_N];

  led_pattern_sequencer #(
    .NUM_STEPS    (NSTEPS),
    .DWELL_W      (22),
    .DWELL_CYCLES (4),
    .LED_ADDR     (32'hFFFFFFFC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tbl_wren     (tbl_wren),
    .tbl_idx      (tbl_idx),
    .tbl_data     (tbl_data),
    .seq_len      (seq_len),
    .mode         (mode),
    .start        (start),
    .stop         (stop),
    .dmem_wren    (dmem_wren),
    .dmem_address (dmem_address),
    .dmem_data_in (dmem_data_in),
    .funct3       (funct3),
    .busy         (busy),
    .done         (done),
    .step_idx     (step_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT updates on the falling edge; outputs are logged on the rising edge.
  always @(posedge clk) begin
    if (log_en && cyc < LOG_N) begin
      l_wren[cyc] = dmem_wren;
      l_data[cyc] = dmem_data_in;
      l_step[cyc] = step_idx;
      l_busy[cyc] = busy;
      l_done[cyc] = done;
      cyc = cyc + 1;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise start for one falling edge; log index 0 is the first WRITE cycle.
  task automatic start_play(input logic [IW:0] len, input logic [1:0] m);
    @(posedge clk);
    #1;
    seq_len = len;
    mode    = m;
    start   = 1'b1;
    cyc     = 0;
    log_en  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic stop_play();
    stop = 1'b1;
    wait_cyc(2);
    stop = 1'b0;
  endtask

  task automatic load_table();
    exp_tbl[0] = 32'hFFFF0000;
    exp_tbl[1] = 32'hFFFFFF00;
    exp_tbl[2] = 32'hFF00FF00;
    for (int i = 0; i < 3; i++) begin
      tbl_wren = 1'b1;
      tbl_idx  = IW'(i);
      tbl_data = exp_tbl[i];
      wait_cyc(1);
    end
    tbl_wren = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wait_cyc(3);
    checks++; if (dmem_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got %b want 0", dmem_wren); end
    checks++; if (dmem_data_in !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 00000000", dmem_data_in); end
    checks++; if (dmem_address !== 32'hFFFFFFFC) begin errors++; $display("FAIL reset_addr got %h want FFFFFFFC", dmem_address); end
    checks++; if (funct3 !== 3'b010) begin errors++; $display("FAIL reset_funct3 got %b want 010", funct3); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (step_idx !== '0) begin errors++; $display("FAIL reset_step got %0d want 0", step_idx); end
    reset_n = 1'b1;
    wait_cyc(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    checks++; if (dmem_wren !== 1'b0) begin errors++; $display("FAIL idle_wren got %b want 0", dmem_wren); end
  endtask

  // Rejected starts: zero length, over-long length, and stop beating start.
  task automatic test_reject();
    logic [IW:0] lens [3];
    logic        stops [3];
    lens[0] = 4'd0; stops[0] = 1'b0;
    lens[1] = 4'd7; stops[1] = 1'b0;
    lens[2] = 4'd3; stops[2] = 1'b1;
    mode = 2'b01;
    for (int s = 0; s < 3; s++) begin
      seq_len = lens[s];
      stop    = stops[s];
      start   = 1'b1;
      cyc     = 0;
      log_en  = 1'b1;
      wait_cyc(6);
      for (int i = 0; i < 6; i++) begin
        checks++; if (l_busy[i] !== 1'b0) begin errors++; $display("FAIL reject%0d_busy[%0d] got %b want 0", s, i, l_busy[i]); end
        checks++; if (l_wren[i] !== 1'b0) begin errors++; $display("FAIL reject%0d_wren[%0d] got %b want 0", s, i, l_wren[i]); end
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    wait_cyc(1);
  endtask

  task automatic test_oneshot();
    logic exp_w;
    start_play(4'd3, 2'b00);
    wait_cyc(19);
    for (int i = 0; i < 20; i++) begin
      exp_w = (i % 5 == 0) && (i <= 10);
      checks++; if (l_wren[i] !== exp_w) begin errors++; $display("FAIL oneshot_wren[%0d] got %b want %b", i, l_wren[i], exp_w); end
      if (exp_w) begin
        checks++; if (l_data[i] !== exp_tbl[i/5]) begin errors++; $display("FAIL oneshot_data[%0d] got %h want %h", i, l_data[i], exp_tbl[i/5]); end
        checks++; if (l_step[i] !== IW'(i/5)) begin errors++; $display("FAIL oneshot_step[%0d] got %0d want %0d", i, l_step[i], i/5); end
      end
      checks++; if (l_done[i] !== (i == 15)) begin errors++; $display("FAIL oneshot_done[%0d] got %b want %b", i, l_done[i], (i == 15)); end
      checks++; if (l_busy[i] !== (i < 15)) begin errors++; $display("FAIL oneshot_busy[%0d] got %b want %b", i, l_busy[i], (i < 15)); end
    end
    checks++; if (l_data[19] !== 32'hFF00FF00) begin errors++; $display("FAIL oneshot_hold got %h want FF00FF00", l_data[19]); end
  endtask

  task automatic test_loop_stop();
    start_play(4'd3, 2'b01);
    wait_cyc(22);
    for (int i = 0; i < 23; i++) begin
      checks++; if (l_wren[i] !== (i % 5 == 0)) begin errors++; $display("FAIL loop_wren[%0d] got %b want %b", i, l_wren[i], (i % 5 == 0)); end
      if (i % 5 == 0) begin
        checks++; if (l_data[i] !== exp_tbl[(i/5)%3]) begin errors++; $display("FAIL loop_data[%0d] got %h want %h", i, l_data[i], exp_tbl[(i/5)%3]); end
        checks++; if (l_step[i] !== IW'((i/5)%3)) begin errors++; $display("FAIL loop_step[%0d] got %0d want %0d", i, l_step[i], (i/5)%3); end
      end
      checks++; if (l_busy[i] !== 1'b1) begin errors++; $display("FAIL loop_busy[%0d] got %b want 1", i, l_busy[i]); end
    end
    stop = 1'b1;
    wait_cyc(1);
    stop = 1'b0;
    wait_cyc(10);
    for (int i = 23; i < 34; i++) begin
      checks++; if (l_busy[i] !== 1'b0) begin errors++; $display("FAIL stop_busy[%0d] got %b want 0", i, l_busy[i]); end
      checks++; if (l_wren[i] !== 1'b0) begin errors++; $display("FAIL stop_wren[%0d] got %b want 0", i, l_wren[i]); end
    end
  endtask

  task automatic test_pingpong();
    int exp_seq [7];
`ifdef LED_SEQ_PINGPONG_EN
    exp_seq = '{0, 1, 2, 1, 0, 1, 2};
`else
    exp_seq = '{0, 1, 2, 0, 1, 2, 0};
`endif
    start_play(4'd3, 2'b10);
    wait_cyc(30);
    for (int k = 0; k < 7; k++) begin
      checks++; if (l_wren[5*k] !== 1'b1) begin errors++; $display("FAIL pp_wren[%0d] got %b want 1", 5*k, l_wren[5*k]); end
      checks++; if (l_step[5*k] !== IW'(exp_seq[k])) begin errors++; $display("FAIL pp_step[%0d] got %0d want %0d", k, l_step[5*k], exp_seq[k]); end
      checks++; if (l_data[5*k] !== exp_tbl[exp_seq[k]]) begin errors++; $display("FAIL pp_data[%0d] got %h want %h", k, l_data[5*k], exp_tbl[exp_seq[k]]); end
    end
    stop_play();
  endtask

  task automatic test_table_write();
    start_play(4'd3, 2'b01);
    wait_cyc(6);
    tbl_wren = 1'b1;
    tbl_idx  = 3'd1;
    tbl_data = 32'h00FF00FF;
    wait_cyc(1);
    tbl_idx  = 3'd7;
    tbl_data = 32'hDEADBEEF;
    wait_cyc(1);
    tbl_wren = 1'b0;
    wait_cyc(17);
    for (int i = 5; i < 10; i++) begin
      checks++; if (l_data[i] !== 32'hFFFFFF00) begin errors++; $display("FAIL tw_hold[%0d] got %h want FFFFFF00", i, l_data[i]); end
    end
    checks++; if (l_data[10] !== 32'hFF00FF00) begin errors++; $display("FAIL tw_step2 got %h want FF00FF00", l_data[10]); end
    checks++; if (l_data[15] !== 32'hFFFF0000) begin errors++; $display("FAIL tw_step0 got %h want FFFF0000", l_data[15]); end
    checks++; if (l_wren[20] !== 1'b1) begin errors++; $display("FAIL tw_wren20 got %b want 1", l_wren[20]); end
    checks++; if (l_step[20] !== 3'd1) begin errors++; $display("FAIL tw_step20 got %0d want 1", l_step[20]); end
    checks++; if (l_data[20] !== 32'h00FF00FF) begin errors++; $display("FAIL tw_new got %h want 00FF00FF", l_data[20]); end
    checks++; if (l_data[25] !== 32'hFF00FF00) begin errors++; $display("FAIL tw_step2b got %h want FF00FF00", l_data[25]); end
    stop_play();
    exp_tbl[1] = 32'h00FF00FF;
  endtask

  task automatic test_reset_mid();
    start_play(4'd3, 2'b01);
    wait_cyc(2);
    checks++; if (dmem_data_in !== exp_tbl[0]) begin errors++; $display("FAIL rm_pre got %h want %h", dmem_data_in, exp_tbl[0]); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (dmem_data_in !== 32'h0) begin errors++; $display("FAIL rm_data got %h want 00000000", dmem_data_in); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b want 0", busy); end
    checks++; if (dmem_wren !== 1'b0) begin errors++; $display("FAIL rm_wren got %b want 0", dmem_wren); end
    checks++; if (step_idx !== '0) begin errors++; $display("FAIL rm_step got %0d want 0", step_idx); end
    wait_cyc(2);
    reset_n = 1'b1;
    wait_cyc(1);
    start_play(4'd3, 2'b01);
    wait_cyc(11);
    for (int k = 0; k < 3; k++) begin
      checks++; if (l_wren[5*k] !== 1'b1) begin errors++; $display("FAIL rz_wren[%0d] got %b want 1", k, l_wren[5*k]); end
      checks++; if (l_data[5*k] !== 32'h0) begin errors++; $display("FAIL rz_data[%0d] got %h want 00000000", k, l_data[5*k]); end
      checks++; if (l_step[5*k] !== IW'(k)) begin errors++; $display("FAIL rz_step[%0d] got %0d want %0d", k, l_step[5*k], k); end
    end
    stop_play();
  endtask

  initial begin
    reset_n  = 1'b0;
    tbl_wren = 1'b0;
    tbl_idx  = '0;
    tbl_data = '0;
    seq_len  = '0;
    mode     = '0;
    start    = 1'b0;
    stop     = 1'b0;
    test_reset();
    test_reject();
    load_table();
    test_oneshot();
    test_loop_stop();
    test_pingpong();
    test_table_write();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
